mlp_weight_loader: RTL and testbench

Upstream stage of the simpleNet MLP datapath. It accepts network weights one word per handshake from a serial source (host/UART/ROM sequencer) and fills a shadow bank. After the last word it commits the complete set atomically to an active bank. The active bank drives the parallel weight bus consumed by simpleNet (word k -> w[k]; words 0-2 node A, 3-5 node B, 6-8 node C), so the network never sees a half-loaded weight set.

---
 rtl/mlp_weight_loader.sv | 110 +++++++++++
 tb/tb_mlp_weight_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_weight_loader.sv
// Serial weight loader: fills a shadow bank one word per handshake and commits
// the complete set atomically to the active bank that drives the weight bus.
module mlp_weight_loader #(
    parameter  int unsigned NUM_W  = 9,
    parameter  int unsigned W_BITS = 4,
    localparam int unsigned CNT_W  = $clog2(NUM_W + 1),
    localparam int unsigned FLAT_W = NUM_W * W_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [W_BITS-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              load_done,
    output logic              weights_valid,
    output logic [CNT_W-1:0]  load_count,
    output logic [FLAT_W-1:0] weights_flat
);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_W - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    load_count_q, load_count_d;
    logic [FLAT_W-1:0]   shadow_q, shadow_d;
    logic [FLAT_W-1:0]   active_q, active_d;
    logic                weights_valid_q, weights_valid_d;
    logic                load_done_q, load_done_d;
    logic                word_accept;

    // State and bank registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            load_count_q    <= '0;
            shadow_q        <= '0;
            active_q        <= '0;
            weights_valid_q <= 1'b0;
            load_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            load_count_q    <= load_count_d;
            shadow_q        <= shadow_d;
            active_q        <= active_d;
            weights_valid_q <= weights_valid_d;
            load_done_q     <= load_done_d;
        end
    end

    // Next-state: abort beats a same-cycle handshake, including on the final word
    always_comb begin
        state_d         = state_q;
        load_count_d    = load_count_q;
        shadow_d        = shadow_q;
        active_d        = active_q;
        weights_valid_d = weights_valid_q;
        load_done_d     = 1'b0;
        word_accept     = in_valid && (state_q == LOAD);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    load_count_d = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d      = IDLE;
                    load_count_d = '0;
                end else if (word_accept) begin
                    for (int unsigned k = 0; k < NUM_W; k++) begin
                        if (load_count_q == CNT_W'(k)) begin
                            shadow_d[k*W_BITS +: W_BITS] = in_data;
                        end
                    end
                    if (load_count_q == LAST_IDX) begin
                        // shadow_d already carries the final word, so commit it whole
                        active_d        = shadow_d;
                        weights_valid_d = 1'b1;
                        load_done_d     = 1'b1;
                        load_count_d    = '0;
                        state_d         = IDLE;
                    end else begin
                        load_count_d = load_count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                load_count_d = '0;
            end
        endcase
    end

    assign in_ready      = (state_q == LOAD);
    assign busy          = (state_q == LOAD);
    assign load_done     = load_done_q;
    assign weights_valid = weights_valid_q;
    assign load_count    = load_count_q;
    assign weights_flat  = active_q;

endmodule

// File: tb/tb_mlp_weight_loader.sv
// Scoreboard bench for mlp_weight_loader: expected committed sets are queued by
// the stimulus and checked by a monitor whenever load_done pulses.
module tb_mlp_weight_loader;

    localparam int unsigned NUM_W  = 9;
    localparam int unsigned W_BITS = 4;
    localparam int unsigned CNT_W  = $clog2(NUM_W + 1);
    localparam int unsigned FLAT_W = NUM_W * W_BITS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [W_BITS-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              load_done;
    logic              weights_valid;
    logic [CNT_W-1:0]  load_count;
    logic [FLAT_W-1:0] weights_flat;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [FLAT_W-1:0] exp_q[$];
    logic              prev_done = 1'b0;

    mlp_weight_loader #(.NUM_W(NUM_W), .W_BITS(W_BITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .busy         (busy),
        .load_done    (load_done),
        .weights_valid(weights_valid),
        .load_count   (load_count),
        .weights_flat (weights_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake counter
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cnt++;
    end

    // Monitor: every load_done must match the oldest queued commit
    always @(negedge clk) begin
        if (rst_n && load_done) begin
            done_cnt++;
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL load_done_back_to_back: got 1 expected 0 at %0t", $time);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load_done: got weights %0h expected no commit at %0t",
                         weights_flat, $time);
            end else begin
                logic [FLAT_W-1:0] e;
                e = exp_q.pop_front();
                if (weights_flat !== e) begin
                    errors++;
                    $display("FAIL commit_weights: got %0h expected %0h at %0t", weights_flat, e, $time);
                end
            end
        end
        prev_done = rst_n && load_done;
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [W_BITS-1:0] d, input bit gap, input bit noise);
        in_valid = 1'b1;
        in_data  = d;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (gap) begin
            start = noise;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic load_set(input logic [FLAT_W-1:0] flat, input bit gap,
                            input bit hold_chk, input logic [FLAT_W-1:0] hold);
        logic [W_BITS-1:0] w;
        exp_q.push_back(flat);
        do_start();
        for (int k = 0; k < int'(NUM_W); k++) begin
            w = flat[k*W_BITS +: W_BITS];
            send_word(w, gap && (k < int'(NUM_W) - 1), gap && (k == 4));
            if (hold_chk && k < int'(NUM_W) - 1) begin
                chk("reload_hold_flat", 64'(weights_flat), 64'(hold));
                chk("reload_hold_valid", 64'(weights_valid), 64'd1);
            end
        end
    endtask

    task automatic chk_idle_after_commit(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(weights_valid), 64'd1);
        chk({tag, "_count"}, 64'(load_count), 64'd0);
    endtask

    task automatic abort_after(input int n_acc, input logic [FLAT_W-1:0] keep);
        do_start();
        for (int k = 0; k < n_acc; k++) send_word(4'hF, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'hF;
        abort    = 1'b1;
        chk("abort_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(load_count), 64'd0);
        chk("abort_flat", 64'(weights_flat), 64'(keep));
        chk("abort_valid", 64'(weights_valid), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int a0, d0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_valid", 64'(weights_valid), 64'd0);
        chk("rst_count", 64'(load_count), 64'd0);
        chk("rst_flat", 64'(weights_flat), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle: in_valid without start is ignored
        in_valid = 1'b1; in_data = 4'h5;
        repeat (5) begin
            @(posedge clk); #1;
            chk("idle_in_ready", 64'(in_ready), 64'd0);
            chk("idle_count", 64'(load_count), 64'd0);
        end
        in_valid = 1'b0;

        // Back-to-back 1..9
        a0 = acc_cnt; d0 = done_cnt;
        load_set(36'h987654321, 1'b0, 1'b0, '0);
        chk("b2b_load_done", 64'(load_done), 64'd1);
        chk_idle_after_commit("b2b");
        chk("b2b_accepts", 64'(acc_cnt - a0), 64'd9);
        @(posedge clk); #1;
        chk("b2b_done_pulse_len", 64'(load_done), 64'd0);
        chk("b2b_done_count", 64'(done_cnt - d0), 64'd1);

        // Gapped load with start re-pulsed mid-load
        a0 = acc_cnt; d0 = done_cnt;
        load_set(36'h210FEDCBA, 1'b1, 1'b0, '0);
        chk_idle_after_commit("gap");
        chk("gap_accepts", 64'(acc_cnt - a0), 64'd9);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("gap_done_count", 64'(done_cnt - d0), 64'd1);

        // Abort with an active set of all 1s, then abort on the final word
        load_set(36'h111111111, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        d0 = done_cnt;
        abort_after(4, 36'h111111111);
        abort_after(8, 36'h111111111);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // Reload coherence
        load_set(36'h987654321, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        load_set(36'h123456789, 1'b0, 1'b1, 36'h987654321);
        chk("reload_new_flat", 64'(weights_flat), 64'h123456789);
        chk_idle_after_commit("reload");
        @(posedge clk); #1;

        // Async reset mid-load
        do_start();
        for (int k = 0; k < 6; k++) send_word(4'h3, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(weights_valid), 64'd0);
        chk("midrst_flat", 64'(weights_flat), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_count", 64'(load_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_idle", 64'(in_ready), 64'd0);
        load_set(36'h777777777, 1'b0, 1'b0, '0);
        chk("sevens_flat", 64'(weights_flat), 64'h777777777);
        chk_idle_after_commit("sevens");

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pending_commits", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
